radio_cal_loopback: RTL and testbench
=====================================

Name: radio_cal_loopback

Overview:
- Sample-level switch between the radio core's TX/RX sample ports and the radio front end.
- Driven by the core's rx_channel_swap setting:
  - Bypass mode: front-end samples pass through unchanged.
  - Loopback mode: TX samples produced by the core are buffered in a FIFO and returned on the core's RX port. This gives an RF-free calibration path.
- The RX strobe cadence seen by the core is always the front-end cadence, because the timekeeper counts rx_stb.

Parameters:
- FIFO_AWIDTH, 4, log2 of loopback FIFO depth (16 entries).
- PRIME_LEVEL, 8, FIFO fill level required before loopback RX data is released; must be in 1..2^FIFO_AWIDTH.

Ports:
- ce_clk  input  1  block clock; all logic on rising edge.
- ce_rst_n  input  1  reset, asynchronous assert, active-low.
- swap_en  input  1  loopback request, level (from rx_channel_swap).
- core_tx  input  32  TX sample from core, {I[31:16],Q[15:0]}.
- core_tx_stb  output  1  TX strobe to core; always equals fe_tx_stb (combinational).
- fe_tx_stb  input  1  DAC-side TX strobe.
- fe_tx  output  32  sample to DAC.
- fe_rx  input  32  ADC sample.
- fe_rx_stb  input  1  ADC-side RX strobe.
- core_rx  output  32  RX sample to core.
- core_rx_stb  output  1  RX strobe to core.
- loop_active  output  1  high in PRIME or LOOP state.
- overflow  output  1  sticky: push to full FIFO occurred; cleared on entry to PRIME.
- underflow  output  1  sticky: pop from empty FIFO in LOOP; cleared on entry to PRIME.

Behaviour:
Reset:
- All outputs 0 except core_tx_stb, which follows fe_tx_stb.
- FIFO empty; state BYPASS.

Latency:
- core_rx, core_rx_stb and fe_tx are registered: 1 cycle after their inputs in every state.
- core_rx_stb <= fe_rx_stb unconditionally, in all states.

States: BYPASS, PRIME, LOOP, FLUSH.
- BYPASS:
  - core_rx <= fe_rx; fe_tx <= core_tx.
  - swap_en=1 -> PRIME; clear overflow and underflow.
- PRIME:
  - fe_tx <= 0 (DAC muted).
  - Push core_tx on each fe_tx_stb.
  - core_rx <= 0 on each fe_rx_stb.
  - fill >= PRIME_LEVEL -> LOOP.
  - swap_en=0 -> FLUSH; this has priority over the transition to LOOP.
- LOOP:
  - fe_tx <= 0; push on fe_tx_stb.
  - On fe_rx_stb: if FIFO not empty, pop and core_rx <= head; if empty, core_rx <= 0 and set underflow.
  - swap_en=0 -> FLUSH.
- FLUSH:
  - One cycle. Reset FIFO pointers; fe_tx <= 0; core_rx <= 0.
  - Always -> BYPASS.

FIFO:
- Pointers are FIFO_AWIDTH+1 bits wide; full/empty are decoded from the MSB compare.
- No fall-through: a push and a pop to an empty FIFO in the same cycle pops nothing (underflow set, zero output); the push lands.
- Push and pop in the same cycle while full: both succeed, and overflow is not set.
- Push while full without a pop: sample dropped, overflow set.
- fill = wr_ptr - rd_ptr, modulo 2^(FIFO_AWIDTH+1).

Mode changes:
- A swap_en change is sampled each cycle and changes state on the next edge.
- The outputs follow the new state one cycle later.

Reset mid-operation:
- Asynchronously returns to BYPASS with the FIFO empty.
- Sticky flags clear.

Optional Feature:
- Macro: RADIO_CAL_LOOPBACK_STATS_EN.
- Defined: adds outputs ovf_count[15:0] and unf_count[15:0].
  - Each is a saturating count (stops at 16'hFFFF) of dropped pushes and empty pops respectively.
  - Both clear on entry to PRIME and on reset.
- Undefined: these ports and counters are absent; the sticky flags are unaffected.

Decomposition:
- Package radio_cal_loopback_pkg holds:
  - the state enum (BYPASS=0, PRIME=1, LOOP=2, FLUSH=3);
  - the sample width constant SAMP_W=32;
  - the zero-sample constant.
- One sub-module, radio_cal_loopback_fifo: synchronous FIFO with push, pop, clear, fill, full and empty. The top level holds the FSM, the muting and the output registers.

Test Plan:
- Bypass:
  - Stimulus: swap_en=0; fe_rx=32'h1234_5678 with fe_rx_stb=1; core_tx=32'hAAAA_5555.
  - Response: next cycle core_rx=32'h1234_5678, core_rx_stb=1, fe_tx=32'hAAAA_5555.
- Priming:
  - Stimulus: swap_en=1; push samples 1..8 on fe_tx_stb; fe_rx_stb every cycle.
  - Response: core_rx=0 until fill=8, then LOOP; core_rx outputs 1,2,3,... in order; fe_tx=0 throughout.
- Underflow:
  - Stimulus: in LOOP, stop fe_tx_stb and keep fe_rx_stb.
  - Response: after 8 pops, core_rx=0 and underflow=1; core_rx_stb continues every cycle.
- Overflow:
  - Stimulus: in PRIME with PRIME_LEVEL=16, hold fe_rx_stb=0 and apply 20 tx strobes.
  - Response: fill=16, overflow=1, samples 17..20 dropped; with STATS_EN, ovf_count=4.
- Exit:
  - Stimulus: drop swap_en in LOOP with 5 samples queued.
  - Response: one FLUSH cycle, then BYPASS; FIFO empty; core_rx resumes tracking fe_rx; re-entering swap_en clears the flags.
- Reset:
  - Stimulus: assert ce_rst_n=0 mid-LOOP, asynchronously between clock edges.
  - Response: outputs 0 immediately; after release, state BYPASS and FIFO empty.

Source files
------------

// File: rtl/radio_cal_loopback_pkg.sv
// Shared types and constants for the radio calibration loopback switch.
package radio_cal_loopback_pkg;

  localparam int SAMP_W = 32;
  localparam logic [SAMP_W-1:0] ZERO_SAMP = '0;

  typedef enum logic [1:0] {
    BYPASS = 2'd0,
    PRIME  = 2'd1,
    LOOP   = 2'd2,
    FLUSH  = 2'd3
  } lb_state_t;

endpackage

// File: rtl/radio_cal_loopback_fifo.sv
// Synchronous sample FIFO; extra pointer MSB tells full from empty.
// No fall-through: a pop while empty returns nothing even if a push lands that cycle.
module radio_cal_loopback_fifo
  import radio_cal_loopback_pkg::*;
#(
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [SAMP_W-1:0] din,
  output logic [SAMP_W-1:0] dout,
  output logic [AWIDTH:0]   fill,
  output logic              full,
  output logic              empty
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [SAMP_W-1:0] mem [DEPTH];
  logic [AWIDTH:0]   wr_ptr;
  logic [AWIDTH:0]   rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AWIDTH] != rd_ptr[AWIDTH]) &&
                 (wr_ptr[AWIDTH-1:0] == rd_ptr[AWIDTH-1:0]);
  assign fill  = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AWIDTH-1:0]];

  // A simultaneous pop frees the slot, so a push to a full FIFO still lands.
  assign wr_ok = push && (!full || pop);
  assign rd_ok = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !clear) mem[wr_ptr[AWIDTH-1:0]] <= din;
  end

endmodule

// File: rtl/radio_cal_loopback.sv
// TX->RX calibration loopback switch between radio core and front end.
// Optional saturating drop/empty-pop counters: define RADIO_CAL_LOOPBACK_STATS_EN.
//
// state  | meaning
// BYPASS | front-end samples pass straight through
// PRIME  | DAC muted, TX samples fill FIFO, core sees zeros
// LOOP   | FIFO contents returned to core on RX strobe
// FLUSH  | one cycle: FIFO emptied, outputs zeroed
module radio_cal_loopback
  import radio_cal_loopback_pkg::*;
#(
  parameter int FIFO_AWIDTH = 4,
  parameter int PRIME_LEVEL = 8
) (
  input  logic              ce_clk,
  input  logic              ce_rst_n,
  input  logic              swap_en,
  input  logic [SAMP_W-1:0] core_tx,
  output logic              core_tx_stb,
  input  logic              fe_tx_stb,
  output logic [SAMP_W-1:0] fe_tx,
  input  logic [SAMP_W-1:0] fe_rx,
  input  logic              fe_rx_stb,
  output logic [SAMP_W-1:0] core_rx,
  output logic              core_rx_stb,
  output logic              loop_active,
  output logic              overflow,
  output logic              underflow
`ifdef RADIO_CAL_LOOPBACK_STATS_EN
  ,
  output logic [15:0]       ovf_count,
  output logic [15:0]       unf_count
`endif
);

  localparam logic [FIFO_AWIDTH:0] PRIME_FILL = (FIFO_AWIDTH+1)'(PRIME_LEVEL);

  lb_state_t             state, state_next;
  logic                  push, pop, clear;
  logic                  full, empty;
  logic [FIFO_AWIDTH:0]  fill;
  logic [SAMP_W-1:0]     head;
  logic [SAMP_W-1:0]     core_rx_next;
  logic                  enter_prime;
  logic                  drop;
  logic                  empty_pop;

  assign core_tx_stb = fe_tx_stb;
  assign loop_active = (state == PRIME) || (state == LOOP);

  assign push        = loop_active && fe_tx_stb;
  assign pop         = (state == LOOP) && fe_rx_stb;
  assign clear       = (state == FLUSH);
  assign enter_prime = (state == BYPASS) && swap_en;
  assign drop        = push && full && !pop;
  assign empty_pop   = pop && empty;

  radio_cal_loopback_fifo #(.AWIDTH(FIFO_AWIDTH)) u_fifo (
    .clk   (ce_clk),
    .rst_n (ce_rst_n),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (core_tx),
    .dout  (head),
    .fill  (fill),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) state <= BYPASS;
    else           state <= state_next;
  end

  // Dropping swap_en wins over reaching the prime level.
  always_comb begin
    state_next   = state;
    core_rx_next = core_rx;
    case (state)
      BYPASS: begin
        core_rx_next = fe_rx;
        if (swap_en) state_next = PRIME;
      end
      PRIME: begin
        if (fe_rx_stb) core_rx_next = ZERO_SAMP;
        if (!swap_en)                 state_next = FLUSH;
        else if (fill >= PRIME_FILL)  state_next = LOOP;
      end
      LOOP: begin
        if (fe_rx_stb) core_rx_next = empty ? ZERO_SAMP : head;
        if (!swap_en) state_next = FLUSH;
      end
      FLUSH: begin
        core_rx_next = ZERO_SAMP;
        state_next   = BYPASS;
      end
      default: state_next = BYPASS;
    endcase
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      core_rx     <= ZERO_SAMP;
      core_rx_stb <= 1'b0;
      fe_tx       <= ZERO_SAMP;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      core_rx     <= core_rx_next;
      core_rx_stb <= fe_rx_stb;
      fe_tx       <= (state == BYPASS) ? core_tx : ZERO_SAMP;
      if (enter_prime) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (drop)      overflow  <= 1'b1;
        if (empty_pop) underflow <= 1'b1;
      end
    end
  end

`ifdef RADIO_CAL_LOOPBACK_STATS_EN
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      ovf_count <= '0;
      unf_count <= '0;
    end else if (enter_prime) begin
      ovf_count <= '0;
      unf_count <= '0;
    end else begin
      if (drop && (ovf_count != 16'hFFFF))      ovf_count <= ovf_count + 16'd1;
      if (empty_pop && (unf_count != 16'hFFFF)) unf_count <= unf_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_radio_cal_loopback.sv
// Directed bench for radio_cal_loopback: bypass, prime/loop, underflow,
// overflow, flush exit and asynchronous reset.
module tb_radio_cal_loopback;

  logic        ce_clk = 1'b0;
  logic        ce_rst_n;
  logic        swap_en;
  logic [31:0] core_tx;
  logic        core_tx_stb;
  logic        fe_tx_stb;
  logic [31:0] fe_tx;
  logic [31:0] fe_rx;
  logic        fe_rx_stb;
  logic [31:0] core_rx;
  logic        core_rx_stb;
  logic        loop_active;
  logic        overflow;
  logic        underflow;
`ifdef RADIO_CAL_LOOPBACK_STATS_EN
  logic [15:0] ovf_count;
  logic [15:0] unf_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 ce_clk = ~ce_clk;

  radio_cal_loopback dut (
    .ce_clk      (ce_clk),
    .ce_rst_n    (ce_rst_n),
    .swap_en     (swap_en),
    .core_tx     (core_tx),
    .core_tx_stb (core_tx_stb),
    .fe_tx_stb   (fe_tx_stb),
    .fe_tx       (fe_tx),
    .fe_rx       (fe_rx),
    .fe_rx_stb   (fe_rx_stb),
    .core_rx     (core_rx),
    .core_rx_stb (core_rx_stb),
    .loop_active (loop_active),
    .overflow    (overflow),
    .underflow   (underflow)
`ifdef RADIO_CAL_LOOPBACK_STATS_EN
    ,
    .ovf_count   (ovf_count),
    .unf_count   (unf_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ce_clk);
    #1;
  endtask

  initial begin
    ce_rst_n  = 1'b0;
    swap_en   = 1'b0;
    core_tx   = '0;
    fe_tx_stb = 1'b0;
    fe_rx     = '0;
    fe_rx_stb = 1'b0;
    #3;
    chk("rst_core_rx", core_rx, 32'h0);
    chk("rst_core_rx_stb", {31'b0, core_rx_stb}, 32'h0);
    chk("rst_fe_tx", fe_tx, 32'h0);
    chk("rst_loop_active", {31'b0, loop_active}, 32'h0);
    chk("rst_flags", {30'b0, overflow, underflow}, 32'h0);
    fe_tx_stb = 1'b1;
    #1;
    chk("rst_core_tx_stb", {31'b0, core_tx_stb}, 32'h1);
    fe_tx_stb = 1'b0;
    #10 ce_rst_n = 1'b1;

    // bypass
    fe_rx = 32'h1234_5678; fe_rx_stb = 1'b1; core_tx = 32'hAAAA_5555; fe_tx_stb = 1'b1;
    tick();
    chk("byp_core_rx", core_rx, 32'h1234_5678);
    chk("byp_core_rx_stb", {31'b0, core_rx_stb}, 32'h1);
    chk("byp_fe_tx", fe_tx, 32'hAAAA_5555);
    fe_rx = 32'h0F0F_0F0F; fe_rx_stb = 1'b0; core_tx = 32'h1357_9BDF; fe_tx_stb = 1'b0;
    tick();
    chk("byp2_core_rx", core_rx, 32'h0F0F_0F0F);
    chk("byp2_core_rx_stb", {31'b0, core_rx_stb}, 32'h0);
    chk("byp2_fe_tx", fe_tx, 32'h1357_9BDF);
    chk("byp2_loop_active", {31'b0, loop_active}, 32'h0);

    // priming: entry edge still applies bypass data
    swap_en = 1'b1; fe_rx = 32'hDEAD_BEEF; fe_rx_stb = 1'b1;
    tick();
    chk("prm_entry_core_rx", core_rx, 32'hDEAD_BEEF);
    chk("prm_loop_active", {31'b0, loop_active}, 32'h1);
    fe_tx_stb = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      core_tx = i;
      tick();
      chk("prm_core_rx", core_rx, 32'h0);
      chk("prm_fe_tx", fe_tx, 32'h0);
      chk("prm_core_rx_stb", {31'b0, core_rx_stb}, 32'h1);
    end
    fe_tx_stb = 1'b0;
    tick();
    chk("prm_last_core_rx", core_rx, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("loop_core_rx", core_rx, i);
      chk("loop_fe_tx", fe_tx, 32'h0);
      chk("loop_underflow", {31'b0, underflow}, 32'h0);
    end
    tick();
    chk("unf_core_rx", core_rx, 32'h0);
    chk("unf_flag", {31'b0, underflow}, 32'h1);
    chk("unf_core_rx_stb", {31'b0, core_rx_stb}, 32'h1);
`ifdef RADIO_CAL_LOOPBACK_STATS_EN
    chk("unf_count", {16'b0, unf_count}, 32'd1);
`endif

    // exit with 5 queued samples
    fe_rx_stb = 1'b0; fe_tx_stb = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      core_tx = 100 + i;
      tick();
      chk("exq_core_rx_hold", core_rx, 32'h0);
    end
    fe_tx_stb = 1'b0; swap_en = 1'b0; fe_rx = 32'h0BAD_CAFE; fe_rx_stb = 1'b1;
    tick();
    chk("exit_last_pop", core_rx, 32'd101);
    chk("exit_flush_active", {31'b0, loop_active}, 32'h0);
    tick();
    chk("flush_core_rx", core_rx, 32'h0);
    tick();
    chk("exit_bypass_core_rx", core_rx, 32'h0BAD_CAFE);
    chk("exit_unf_sticky", {31'b0, underflow}, 32'h1);

    // re-entry clears flags; overflow with no pops
    swap_en = 1'b1; fe_rx_stb = 1'b0;
    tick();
    chk("reent_flags", {30'b0, overflow, underflow}, 32'h0);
    fe_tx_stb = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      core_tx = 200 + i;
      tick();
      if (i == 16) chk("ovf_at16", {31'b0, overflow}, 32'h0);
    end
    chk("ovf_flag", {31'b0, overflow}, 32'h1);
`ifdef RADIO_CAL_LOOPBACK_STATS_EN
    chk("ovf_count", {16'b0, ovf_count}, 32'd4);
`endif
    fe_tx_stb = 1'b0; fe_rx_stb = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("ovf_drain", core_rx, 200 + i);
    end
    tick();
    chk("ovf_drain_empty", core_rx, 32'h0);
    chk("ovf_drain_unf", {31'b0, underflow}, 32'h1);

    // async reset mid-LOOP with a sample still queued
    fe_rx_stb = 1'b0; fe_tx_stb = 1'b1; core_tx = 32'd300;
    tick();
    core_tx = 32'd301;
    tick();
    fe_tx_stb = 1'b0; fe_rx_stb = 1'b1;
    tick();
    chk("prerst_core_rx", core_rx, 32'd300);
    #3 ce_rst_n = 1'b0;
    #1;
    chk("arst_core_rx", core_rx, 32'h0);
    chk("arst_core_rx_stb", {31'b0, core_rx_stb}, 32'h0);
    chk("arst_fe_tx", fe_tx, 32'h0);
    chk("arst_loop_active", {31'b0, loop_active}, 32'h0);
    chk("arst_flags", {30'b0, overflow, underflow}, 32'h0);
    #2 ce_rst_n = 1'b1;
    swap_en = 1'b0; fe_rx = 32'h5A5A_A5A5;
    tick();
    chk("post_rst_core_rx", core_rx, 32'h5A5A_A5A5);
    chk("post_rst_loop_active", {31'b0, loop_active}, 32'h0);
    swap_en = 1'b1; fe_rx_stb = 1'b0;
    tick();
    fe_tx_stb = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      core_tx = 400 + i;
      tick();
    end
    fe_tx_stb = 1'b0;
    tick();
    fe_rx_stb = 1'b1;
    tick();
    chk("post_rst_first_pop", core_rx, 32'd401);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
